// File: rtl/frame_pair_streamer.sv
// rtl/frame_pair_streamer.sv - one-frame delay line emitting {current, previous-frame} pixel pairs
// Priming frame after reset/restart fills memory only; later frames stream lock-stepped pairs.
module frame_pair_streamer #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int FCW    = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           restart,
  input  logic [7:0]     recv_pix,
  input  logic           recv_pix_val,
  output logic           recv_pix_rdy,
  output logic [7:0]     send_curr,
  output logic           send_curr_val,
  input  logic           send_curr_rdy,
  output logic [7:0]     send_prev,
  output logic           send_prev_val,
  input  logic           send_prev_rdy,
  output logic           frame_done,
  output logic [FCW-1:0] frame_count
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    S_PRIME  = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_en;
  logic [AW-1:0]  r_addr;
  logic [7:0]     r_mem [DEPTH];
  logic           r_full;
  logic [7:0]     r_curr;
  logic [7:0]     r_prev;
  logic [FCW-1:0] r_fcnt;

  logic           w_rdy;
  logic           w_accept;
  logic           w_last;
  logic           w_xfer;
  logic           w_both_rdy;
  logic [7:0]     w_old;

  assign w_both_rdy = send_curr_rdy && send_prev_rdy;
  assign w_accept   = recv_pix_val && w_rdy;
  assign w_last     = (r_addr == LAST_ADDR);
  assign w_xfer     = r_full && w_both_rdy;
  assign w_old      = r_mem[r_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_PRIME;
    end else if (restart) begin
      r_state <= S_PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PRIME:  if (w_accept && w_last) w_state_nxt = S_STREAM;
      S_STREAM: w_state_nxt = S_STREAM;
      default:  w_state_nxt = S_PRIME;
    endcase
  end

  // r_en keeps the input closed until the first edge after reset release
  always_comb begin
    w_rdy = 1'b0;
    case (r_state)
      S_PRIME:  w_rdy = r_en && !restart;
      S_STREAM: w_rdy = r_en && !restart && (!r_full || w_both_rdy);
      default:  w_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en <= 1'b0;
    end else begin
      r_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_fcnt <= '0;
    end else if (restart) begin
      r_addr <= '0;
      r_fcnt <= '0;
    end else if (w_accept) begin
      r_addr <= w_last ? '0 : r_addr + 1'b1;
      if (w_last) r_fcnt <= r_fcnt + 1'b1;
    end
  end

  // Frame store is never reset; the old value is read in the same cycle it is overwritten
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_addr] <= recv_pix;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_curr <= '0;
      r_prev <= '0;
    end else if (restart) begin
      r_full <= 1'b0;
    end else if (w_accept && (r_state == S_STREAM)) begin
      r_full <= 1'b1;
      r_curr <= recv_pix;
      r_prev <= w_old;
    end else if (w_xfer) begin
      r_full <= 1'b0;
    end
  end

  assign recv_pix_rdy  = w_rdy;
  assign send_curr     = r_curr;
  assign send_prev     = r_prev;
  assign send_curr_val = r_full;
  assign send_prev_val = r_full;
  assign frame_done    = w_accept && w_last;
  assign frame_count   = r_fcnt;

endmodule
